// File: rtl/vend_pkg.sv
// Shared encodings for the vending credit controller: FSM states, coin
// types with their credit values, the change unit and the credit-mux select.
package vend_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COLLECT    = 3'd1;
  localparam logic [2:0] ST_DISPENSE   = 3'd2;
  localparam logic [2:0] ST_CHANGE_ON  = 3'd3;
  localparam logic [2:0] ST_CHANGE_OFF = 3'd4;

  // coin_type encodings
  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  // Credit values of the accepted coins, and the payout step
  localparam logic [7:0] COIN_5_VAL  = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;
  localparam logic [7:0] COIN_25_VAL = 8'd25;
  localparam logic [7:0] CHANGE_UNIT = 8'd5;

  // Select for the next-credit mux in front of the credit register
  typedef enum logic [2:0] {
    CR_HOLD,
    CR_ADD,
    CR_SUB_PRICE,
    CR_SUB_UNIT,
    CR_ZERO
  } credit_op_e;

  // Credit value of a coin; the invalid code maps to 0 and is rejected anyway
  function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
    logic [7:0] v;
    case (coin_type)
      COIN_5:  v = COIN_5_VAL;
      COIN_10: v = COIN_10_VAL;
      COIN_25: v = COIN_25_VAL;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/Register.sv
// Plain storage register with synchronous active-high reset; loads data_in
// every cycle, so the owner holds its value by feeding it back.
module Register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Load every cycle, clear on reset
  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else       data_out <= data_in;
  end

endmodule

// File: rtl/vend_credit_controller.sv
// Vending credit sequencer: accumulates coins, serves selections against
// fixed prices, holds the dispense handshake and pays change in 5-unit pulses.
//
// Handshake: dispense_req is a level that rises the cycle after an accepted
// selection and stays high (with dispense_item stable) until dispense_ack is
// sampled high in DISPENSE; it drops the following cycle. ack outside
// DISPENSE has no effect. state_dbg mirrors the FSM state register.
module vend_credit_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A    = 15,
  parameter int PRICE_B    = 25,
  parameter int MAX_CREDIT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic       sel_item,
  input  logic       cancel,
  input  logic       dispense_ack,
  output logic [7:0] credit,
  output logic       dispense_req,
  output logic       dispense_item,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       sel_nack,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] PRICE_A_C = PRICE_A[7:0];
  localparam logic [7:0] PRICE_B_C = PRICE_B[7:0];
  localparam logic [8:0] MAX_C     = MAX_CREDIT[8:0];

  logic [2:0] state_q, state_d;
  logic       dispense_item_q, dispense_item_d;
  logic       coin_reject_q, coin_reject_d;
  logic       sel_nack_q, sel_nack_d;
  logic [7:0] credit_d;
  logic [7:0] coin_val;
  logic [7:0] price;
  logic [8:0] sum9;
  logic       coin_ok;
  logic       can_pay;
  credit_op_e credit_op;

  assign coin_val = coin_value(coin_type);
  assign sum9     = {1'b0, credit} + {1'b0, coin_val};
  assign coin_ok  = (coin_type != COIN_BAD) && (sum9 <= MAX_C);
  assign price    = sel_item ? PRICE_B_C : PRICE_A_C;
  assign can_pay  = credit >= price;

  // Next state, pulse requests and credit-mux select
  always_comb begin
    state_d         = state_q;
    dispense_item_d = dispense_item_q;
    coin_reject_d   = 1'b0;
    sel_nack_d      = 1'b0;
    credit_op       = CR_HOLD;
    case (state_q)
      ST_IDLE: begin
        credit_op = CR_ZERO;
        if (coin_valid) begin
          if (coin_ok) begin
            credit_op = CR_ADD;
            state_d   = ST_COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (sel_valid) sel_nack_d = 1'b1;
      end
      ST_COLLECT: begin
        if (cancel) begin
          // A coin arriving with a cancel is handed back, not banked
          coin_reject_d = coin_valid;
          state_d       = (credit != 8'd0) ? ST_CHANGE_ON : ST_IDLE;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (can_pay) begin
            credit_op       = CR_SUB_PRICE;
            dispense_item_d = sel_item;
            state_d         = ST_DISPENSE;
          end else begin
            sel_nack_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) credit_op = CR_ADD;
          else         coin_reject_d = 1'b1;
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        if (dispense_ack) state_d = (credit == 8'd0) ? ST_IDLE : ST_CHANGE_ON;
      end
      ST_CHANGE_ON: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        credit_op     = CR_SUB_UNIT;
        state_d       = ST_CHANGE_OFF;
      end
      ST_CHANGE_OFF: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        state_d       = (credit == 8'd0) ? ST_IDLE : ST_CHANGE_ON;
      end
      default: begin
        credit_op = CR_ZERO;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Next-credit mux feeding the credit register
  always_comb begin
    credit_d = credit;
    case (credit_op)
      CR_HOLD:      credit_d = credit;
      CR_ADD:       credit_d = credit + coin_val;
      CR_SUB_PRICE: credit_d = credit - price;
      CR_SUB_UNIT:  credit_d = credit - CHANGE_UNIT;
      CR_ZERO:      credit_d = 8'd0;
      default:      credit_d = credit;
    endcase
  end

  // FSM, refusal pulses and the latched item
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      dispense_item_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      sel_nack_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      dispense_item_q <= dispense_item_d;
      coin_reject_q   <= coin_reject_d;
      sel_nack_q      <= sel_nack_d;
    end
  end

  Register #(.WIDTH(8)) u_credit_reg (
    .clk      (clk),
    .reset    (reset),
    .data_in  (credit_d),
    .data_out (credit)
  );

  assign dispense_req  = (state_q == ST_DISPENSE);
  assign change_pulse  = (state_q == ST_CHANGE_ON);
  assign busy          = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE_ON) ||
                         (state_q == ST_CHANGE_OFF);
  assign dispense_item = dispense_item_q;
  assign coin_reject   = coin_reject_q;
  assign sel_nack      = sel_nack_q;
  assign state_dbg     = state_q;

endmodule
